// File: rtl/hack_ram_arbiter.sv
// Round-robin arbiter sharing the Hack SoC single-port data RAM between the
// CPU data port and the Caravel management Wishbone slave.
module hack_ram_arbiter #(
    parameter int          ADDR_W  = 15,
    parameter int          DATA_W  = 16,
    parameter logic [31:0] WB_BASE = 32'h3000_0000,
    parameter logic [31:0] WB_MASK = 32'hFFFE_0000
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    input  logic              cpu_hold,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_WB  = 1'b1;

    logic [1:0]        r_state;
    logic              r_owner;
    logic              r_last_grant;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              r_we;
    logic [DATA_W-1:0] r_cpu_rdata;

    logic w_wb_hit;
    logic w_cpu_pend;
    logic w_grant_wb;
    logic w_grant_cpu;
    logic w_wb_we;
    logic w_access;
    logic w_resp;
    logic w_wb_resp;
    logic w_unused_bits;

    assign w_wb_hit    = wbs_cyc_i & wbs_stb_i & ((wbs_adr_i & WB_MASK) == WB_BASE);
    assign w_cpu_pend  = cpu_req & ~cpu_hold;
    // On a tie the requester that did not win last time goes first.
    assign w_grant_wb  = w_wb_hit & (~w_cpu_pend | (r_last_grant == OWN_CPU));
    assign w_grant_cpu = w_cpu_pend & ~w_grant_wb;
    // A write with no low byte lane selected degrades to a harmless read.
    assign w_wb_we     = wbs_we_i & (|wbs_sel_i[1:0]);

    assign w_unused_bits = ^{wbs_sel_i[3:2], wbs_dat_i[31:DATA_W]};

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state      <= S_IDLE;
            r_owner      <= OWN_CPU;
            r_last_grant <= OWN_WB;
            r_cpu_rdata  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_wb) begin
                        r_owner      <= OWN_WB;
                        r_last_grant <= OWN_WB;
                        r_state      <= S_ACCESS;
                    end else if (w_grant_cpu) begin
                        r_owner      <= OWN_CPU;
                        r_last_grant <= OWN_CPU;
                        r_state      <= S_ACCESS;
                    end
                end
                S_ACCESS: r_state <= S_RESP;
                S_RESP: begin
                    if (r_owner == OWN_CPU) begin
                        r_cpu_rdata <= ram_dout;
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Access operands are only observed while in ACCESS, so they need no reset.
    always_ff @(posedge wb_clk_i) begin
        if (r_state == S_IDLE) begin
            if (w_grant_wb) begin
                r_addr <= wbs_adr_i[ADDR_W+1:2];
                r_data <= wbs_dat_i[DATA_W-1:0];
                r_we   <= w_wb_we;
            end else if (w_grant_cpu) begin
                r_addr <= cpu_addr;
                r_data <= cpu_wdata;
                r_we   <= cpu_we;
            end
        end
    end

    assign w_access  = (r_state == S_ACCESS);
    assign w_resp    = (r_state == S_RESP);
    assign w_wb_resp = w_resp & (r_owner == OWN_WB);

    assign ram_en   = w_access;
    assign ram_we   = w_access & r_we;
    assign ram_addr = w_access ? r_addr : '0;
    assign ram_din  = w_access ? r_data : '0;

    assign cpu_ready = w_resp & (r_owner == OWN_CPU);
    assign cpu_rdata = cpu_ready ? ram_dout : r_cpu_rdata;

    // A master that abandoned its cycle gets no ack; the RAM access still finished.
    assign wbs_ack_o = w_wb_resp & wbs_cyc_i & wbs_stb_i;
    assign wbs_dat_o = (w_wb_resp & ~r_we) ? {{(32-DATA_W){1'b0}}, ram_dout} : 32'd0;

endmodule

// File: tb/tb_hack_ram_arbiter.sv
// Directed bench for hack_ram_arbiter: per-cycle vector table plus hand-written
// sequences for contention, cpu_hold, Wishbone abort and reset mid-access.
module tb_hack_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat;
    logic        ack;
    logic [31:0] wdat;
    logic        hold, req, cwe;
    logic [14:0] caddr;
    logic [15:0] cwd;
    logic [15:0] rdata;
    logic        rdy;
    logic        ram_en, ram_we;
    logic [14:0] ram_addr;
    logic [15:0] ram_din;
    logic [15:0] ram_dout;
    logic [15:0] mem [0:32767];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    hack_ram_arbiter dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wbs_cyc_i(cyc),
        .wbs_stb_i(stb),
        .wbs_we_i (we),
        .wbs_sel_i(sel),
        .wbs_adr_i(adr),
        .wbs_dat_i(dat),
        .wbs_ack_o(ack),
        .wbs_dat_o(wdat),
        .cpu_hold (hold),
        .cpu_req  (req),
        .cpu_we   (cwe),
        .cpu_addr (caddr),
        .cpu_wdata(cwd),
        .cpu_rdata(rdata),
        .cpu_ready(rdy),
        .ram_en   (ram_en),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_dout (ram_dout)
    );

    // Synchronous single-port RAM: read data appears the cycle after the enable.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_din;
            else        ram_dout <= mem[ram_addr];
        end
    end

    typedef struct packed {
        logic [2:0]  wb;      // cyc, stb, we
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [2:0]  cpu;     // hold, req, we
        logic [14:0] caddr;
        logic [15:0] cwd;
        logic [1:0]  e_ram;   // ram_en, ram_we
        logic [14:0] e_addr;
        logic [15:0] e_din;
        logic        e_ack;
        logic [31:0] e_wdat;
        logic        e_rdy;
        logic [15:0] e_rdata;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t V(input logic [2:0] wb_c, input logic [3:0] s,
                               input logic [31:0] a, input logic [31:0] d,
                               input logic [2:0] cpu_c, input logic [14:0] ca,
                               input logic [15:0] cd, input logic [1:0] er,
                               input logic [14:0] ea, input logic [15:0] ed,
                               input logic eack, input logic [31:0] ewd,
                               input logic erdy, input logic [15:0] erd);
        vec_t v;
        v.wb = wb_c; v.sel = s; v.adr = a; v.dat = d;
        v.cpu = cpu_c; v.caddr = ca; v.cwd = cd;
        v.e_ram = er; v.e_addr = ea; v.e_din = ed;
        v.e_ack = eack; v.e_wdat = ewd; v.e_rdy = erdy; v.e_rdata = erd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        cyc = 0; stb = 0; we = 0; sel = 4'h0; adr = '0; dat = '0;
        hold = 0; req = 0; cwe = 0; caddr = '0; cwd = '0;
    endtask

    task automatic chk_quiet(input string nm);
        chk({nm, " ram_en"}, {31'd0, ram_en}, 32'd0);
        chk({nm, " ack"},    {31'd0, ack},    32'd0);
        chk({nm, " ready"},  {31'd0, rdy},    32'd0);
        chk({nm, " wdat"},   wdat,            32'd0);
    endtask

    localparam logic [2:0] WBN = 3'b000, WBW = 3'b111, WBR = 3'b110;
    localparam logic [2:0] CN = 3'b000, CR = 3'b010, CW = 3'b011;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks, rdys;
        clear_in();
        rst = 1;
        tick(); tick();
        chk_quiet("reset");
        chk("reset ram_we",   {31'd0, ram_we}, 32'd0);
        chk("reset ram_addr", {17'd0, ram_addr}, 32'd0);
        chk("reset ram_din",  {16'd0, ram_din}, 32'd0);
        chk("reset rdata",    {16'd0, rdata}, 32'd0);
        rst = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk($sformatf("idle%0d ram_en", i), {31'd0, ram_en}, 32'd0);
        end

        tv.push_back(V(WBN, 4'h0, 32'h0,         32'h0,    CN, 15'd0, 16'h0,    2'b00, 15'd0, 16'h0,    0, 32'h0,      0, 16'h0));
        tv.push_back(V(WBW, 4'hF, 32'h3000_0010, 32'hBEEF, CN, 15'd0, 16'h0,    2'b11, 15'd4, 16'hBEEF, 0, 32'h0,      0, 16'h0));
        tv.push_back(V(WBW, 4'hF, 32'h3000_0010, 32'hBEEF, CN, 15'd0, 16'h0,    2'b00, 15'd0, 16'h0,    1, 32'h0,      0, 16'h0));
        tv.push_back(V(WBN, 4'h0, 32'h0,         32'h0,    CN, 15'd0, 16'h0,    2'b00, 15'd0, 16'h0,    0, 32'h0,      0, 16'h0));
        tv.push_back(V(WBR, 4'hF, 32'h3000_0010, 32'h0,    CN, 15'd0, 16'h0,    2'b10, 15'd4, 16'h0,    0, 32'h0,      0, 16'h0));
        tv.push_back(V(WBR, 4'hF, 32'h3000_0010, 32'h0,    CN, 15'd0, 16'h0,    2'b00, 15'd0, 16'h0,    1, 32'hBEEF,   0, 16'h0));
        tv.push_back(V(WBN, 4'h0, 32'h0,         32'h0,    CN, 15'd0, 16'h0,    2'b00, 15'd0, 16'h0,    0, 32'h0,      0, 16'h0));
        tv.push_back(V(WBN, 4'h0, 32'h0,         32'h0,    CR, 15'd4, 16'h0,    2'b10, 15'd4, 16'h0,    0, 32'h0,      0, 16'h0));
        tv.push_back(V(WBN, 4'h0, 32'h0,         32'h0,    CR, 15'd4, 16'h0,    2'b00, 15'd0, 16'h0,    0, 32'h0,      1, 16'hBEEF));
        tv.push_back(V(WBN, 4'h0, 32'h0,         32'h0,    CN, 15'd0, 16'h0,    2'b00, 15'd0, 16'h0,    0, 32'h0,      0, 16'hBEEF));
        tv.push_back(V(WBN, 4'h0, 32'h0,         32'h0,    CW, 15'd7, 16'h1234, 2'b11, 15'd7, 16'h1234, 0, 32'h0,      0, 16'hBEEF));
        tv.push_back(V(WBN, 4'h0, 32'h0,         32'h0,    CW, 15'd7, 16'h1234, 2'b00, 15'd0, 16'h0,    0, 32'h0,      1, 16'hBEEF));
        tv.push_back(V(WBN, 4'h0, 32'h0,         32'h0,    CN, 15'd0, 16'h0,    2'b00, 15'd0, 16'h0,    0, 32'h0,      0, 16'hBEEF));
        tv.push_back(V(WBR, 4'hF, 32'h2000_0000, 32'h0,    CN, 15'd0, 16'h0,    2'b00, 15'd0, 16'h0,    0, 32'h0,      0, 16'hBEEF));
        tv.push_back(V(WBR, 4'hF, 32'h2000_0000, 32'h0,    CN, 15'd0, 16'h0,    2'b00, 15'd0, 16'h0,    0, 32'h0,      0, 16'hBEEF));
        tv.push_back(V(WBW, 4'h0, 32'h3000_0010, 32'hAAAA, CN, 15'd0, 16'h0,    2'b10, 15'd4, 16'hAAAA, 0, 32'h0,      0, 16'hBEEF));
        tv.push_back(V(WBW, 4'h0, 32'h3000_0010, 32'hAAAA, CN, 15'd0, 16'h0,    2'b00, 15'd0, 16'h0,    1, 32'hBEEF,   0, 16'hBEEF));
        tv.push_back(V(WBN, 4'h0, 32'h0,         32'h0,    CN, 15'd0, 16'h0,    2'b00, 15'd0, 16'h0,    0, 32'h0,      0, 16'hBEEF));
        tv.push_back(V(WBW, 4'h1, 32'h3000_0018, 32'h5A5A, CN, 15'd0, 16'h0,    2'b11, 15'd6, 16'h5A5A, 0, 32'h0,      0, 16'hBEEF));
        tv.push_back(V(WBW, 4'h1, 32'h3000_0018, 32'h5A5A, CN, 15'd0, 16'h0,    2'b00, 15'd0, 16'h0,    1, 32'h0,      0, 16'hBEEF));
        tv.push_back(V(WBN, 4'h0, 32'h0,         32'h0,    CN, 15'd0, 16'h0,    2'b00, 15'd0, 16'h0,    0, 32'h0,      0, 16'hBEEF));
        tv.push_back(V(WBR, 4'hF, 32'h3000_001C, 32'h0,    CN, 15'd0, 16'h0,    2'b10, 15'd7, 16'h0,    0, 32'h0,      0, 16'hBEEF));
        tv.push_back(V(WBR, 4'hF, 32'h3000_001C, 32'h0,    CN, 15'd0, 16'h0,    2'b00, 15'd0, 16'h0,    1, 32'h1234,   0, 16'hBEEF));
        tv.push_back(V(WBN, 4'h0, 32'h0,         32'h0,    CN, 15'd0, 16'h0,    2'b00, 15'd0, 16'h0,    0, 32'h0,      0, 16'hBEEF));
        tv.push_back(V(WBR, 4'hF, 32'h3000_0018, 32'h0,    CN, 15'd0, 16'h0,    2'b10, 15'd6, 16'h0,    0, 32'h0,      0, 16'hBEEF));
        tv.push_back(V(WBR, 4'hF, 32'h3000_0018, 32'h0,    CN, 15'd0, 16'h0,    2'b00, 15'd0, 16'h0,    1, 32'h5A5A,   0, 16'hBEEF));
        tv.push_back(V(WBN, 4'h0, 32'h0,         32'h0,    CN, 15'd0, 16'h0,    2'b00, 15'd0, 16'h0,    0, 32'h0,      0, 16'hBEEF));

        foreach (tv[i]) begin
            {cyc, stb, we} = tv[i].wb;
            sel = tv[i].sel; adr = tv[i].adr; dat = tv[i].dat;
            {hold, req, cwe} = tv[i].cpu;
            caddr = tv[i].caddr; cwd = tv[i].cwd;
            tick();
            chk($sformatf("v%0d ram_en", i),   {31'd0, ram_en},   {31'd0, tv[i].e_ram[1]});
            chk($sformatf("v%0d ram_we", i),   {31'd0, ram_we},   {31'd0, tv[i].e_ram[0]});
            chk($sformatf("v%0d ram_addr", i), {17'd0, ram_addr}, {17'd0, tv[i].e_addr});
            chk($sformatf("v%0d ram_din", i),  {16'd0, ram_din},  {16'd0, tv[i].e_din});
            chk($sformatf("v%0d ack", i),      {31'd0, ack},      {31'd0, tv[i].e_ack});
            chk($sformatf("v%0d wdat", i),     wdat,              tv[i].e_wdat);
            chk($sformatf("v%0d ready", i),    {31'd0, rdy},      {31'd0, tv[i].e_rdy});
            chk($sformatf("v%0d rdata", i),    {16'd0, rdata},    {16'd0, tv[i].e_rdata});
        end

        // Contention right after reset: CPU first, then strict alternation.
        clear_in();
        rst = 1;
        tick(); tick();
        chk_quiet("rst2");
        chk("rst2 rdata", {16'd0, rdata}, 32'd0);
        rst = 0;
        req = 1; caddr = 15'd4;
        cyc = 1; stb = 1; we = 0; sel = 4'hF; adr = 32'h3000_0018;
        for (int i = 1; i <= 12; i++) begin
            int ph, n;
            logic cpu_turn;
            tick();
            ph = (i - 1) % 3;
            n = (i - 1) / 3;
            cpu_turn = (n % 2 == 0);
            if (ph == 0) begin
                chk($sformatf("rr%0d ram_en", n), {31'd0, ram_en}, 32'd1);
                chk($sformatf("rr%0d owner_addr", n), {17'd0, ram_addr}, cpu_turn ? 32'd4 : 32'd6);
            end else if (ph == 1) begin
                chk($sformatf("rr%0d ready", n), {31'd0, rdy}, {31'd0, cpu_turn});
                chk($sformatf("rr%0d ack", n), {31'd0, ack}, {31'd0, ~cpu_turn});
                if (cpu_turn) chk($sformatf("rr%0d rdata", n), {16'd0, rdata}, 32'hBEEF);
                else          chk($sformatf("rr%0d wdat", n), wdat, 32'h5A5A);
            end else begin
                chk($sformatf("rr%0d idle", n), {31'd0, ram_en}, 32'd0);
            end
        end
        clear_in();
        tick();

        // cpu_hold keeps the CPU out while WB writes stream through.
        hold = 1; req = 1; caddr = 15'd4;
        cyc = 1; stb = 1; we = 1; sel = 4'hF; adr = 32'h3000_0020; dat = 32'h1111;
        acks = 0; rdys = 0;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (ack) acks++;
            if (rdy) rdys++;
            if (i % 3 == 0) chk($sformatf("hold%0d wb_addr", i), {17'd0, ram_addr}, 32'd8);
        end
        chk("hold ack count", acks, 32'd3);
        chk("hold ready count", rdys, 32'd0);
        hold = 0;
        tick();
        chk("unhold cpu grant", {17'd0, ram_addr}, 32'd4);
        chk("unhold ram_we", {31'd0, ram_we}, 32'd0);
        hold = 1;
        tick();
        chk("late hold ready", {31'd0, rdy}, 32'd1);
        chk("late hold rdata", {16'd0, rdata}, 32'hBEEF);
        chk("late hold ack", {31'd0, ack}, 32'd0);
        clear_in();
        tick();
        chk_quiet("post hold");

        // Wishbone abort: strobe dropped during ACCESS.
        cyc = 1; stb = 1; we = 1; sel = 4'hF; adr = 32'h3000_0024; dat = 32'h7777;
        tick();
        chk("abort ram_en", {31'd0, ram_en}, 32'd1);
        chk("abort ram_we", {31'd0, ram_we}, 32'd1);
        chk("abort ram_addr", {17'd0, ram_addr}, 32'd9);
        stb = 0;
        tick();
        chk("abort ack", {31'd0, ack}, 32'd0);
        tick();
        chk_quiet("abort idle");
        chk("abort mem", {16'd0, mem[9]}, 32'h7777);
        stb = 1; we = 0;
        tick(); tick();
        chk("abort readback ack", {31'd0, ack}, 32'd1);
        chk("abort readback", wdat, 32'h7777);
        clear_in();
        tick();

        // Reset while an access is in flight.
        req = 1; caddr = 15'd6;
        tick();
        chk("rstacc ram_en", {31'd0, ram_en}, 32'd1);
        chk("rstacc ram_addr", {17'd0, ram_addr}, 32'd6);
        rst = 1;
        tick();
        chk_quiet("rstacc killed");
        rst = 0; req = 0;
        tick();
        chk_quiet("rstacc after");
        chk("rstacc rdata", {16'd0, rdata}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hack_ram_arbiter.md
Name: hack_ram_arbiter

Overview:
Shares the Hack SoC's single-port 16-bit data RAM between two requesters: the Hack CPU data port and the Caravel management Wishbone slave port. A small FSM grants one access at a time with round-robin arbitration and sequences the RAM's synchronous read timing. It returns data and completion strobes to the winner. The block sits inside caravel_hack_soc, between the Wishbone slave inputs, the CPU core and the RAM macro.

Parameters:
ADDR_W, 15, RAM word-address width (32K words)
DATA_W, 16, RAM data width
WB_BASE, 32'h3000_0000, Wishbone base address of the RAM window
WB_MASK, 32'hFFFE_0000, address bits compared against WB_BASE

Ports:
wb_clk_i  in  1  sole clock; all logic on rising edge
wb_rst_i  in  1  synchronous, active-high reset
wbs_cyc_i  in  1  Wishbone cycle
wbs_stb_i  in  1  Wishbone strobe
wbs_we_i  in  1  Wishbone write enable
wbs_sel_i  in  4  byte selects
wbs_adr_i  in  32  byte address; RAM word = wbs_adr_i[ADDR_W+1:2]
wbs_dat_i  in  32  write data; bits [DATA_W-1:0] used
wbs_ack_o  out  1  one-cycle acknowledge
wbs_dat_o  out  32  read data, {16'b0, word}
cpu_hold  in  1  1 = CPU requests are not granted (program loading)
cpu_req  in  1  CPU access request, held until cpu_ready
cpu_we  in  1  CPU write
cpu_addr  in  ADDR_W  CPU word address
cpu_wdata  in  DATA_W  CPU write data
cpu_rdata  out  DATA_W  CPU read data
cpu_ready  out  1  one-cycle completion strobe
ram_en  out  1  RAM enable
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_W  RAM address
ram_din  out  DATA_W  RAM write data
ram_dout  in  DATA_W  RAM read data; valid the cycle after an enabled read

Behaviour:
- WB hit = wbs_cyc_i & wbs_stb_i & ((wbs_adr_i & WB_MASK) == WB_BASE). This block never acks a miss.
- CPU pending = cpu_req & ~cpu_hold.
- FSM states: IDLE, ACCESS, RESP. Registers: owner (CPU/WB), last_grant, addr_q, data_q, we_q.
- IDLE: ram_en=0. If one requester is pending, it wins. If both are pending, the winner is the one that is not last_grant. On the edge, capture the winner's addr/data/we, set owner and last_grant, and go to ACCESS.
- ACCESS (1 cycle): ram_en=1, ram_we=we_q, ram_addr=addr_q, ram_din=data_q. Always go to RESP.
- RESP (1 cycle): ram_dout is valid for reads.
  - Owner CPU: cpu_ready=1 and cpu_rdata=ram_dout.
  - Owner WB: wbs_ack_o = wbs_cyc_i & wbs_stb_i, and wbs_dat_o={16'b0, ram_dout} (0 for writes).
  - Always go to IDLE.
- Latency: request sampled in IDLE at edge k → ACCESS cycle k+1 → strobe in cycle k+2. Peak throughput is one access per 3 cycles.
- Outside RESP: wbs_ack_o=0, cpu_ready=0, wbs_dat_o=0. cpu_rdata holds its last value (register updated in RESP).
- WB write with wbs_sel_i[1:0]==2'b00: we_q forced to 0 (RAM is read, not written); the access is still acked.
- Partial sel (01 or 10): a full 16-bit word is written.
- WB abort (cyc or stb dropped after grant): the RAM access still completes and no ack is issued. The FSM continues through RESP to IDLE.
- cpu_hold asserted after a CPU grant does not cancel that access.
- Round-robin bounds waiting: with both requesters continuously pending, grants alternate CPU, WB, CPU, ...
- Reset: state=IDLE, last_grant=WB (the CPU wins the first tie), all outputs 0, cpu_rdata=0.
  - Reset mid-ACCESS: ram_en is 0 from the next cycle and no strobe is issued for the killed access.

Test Plan:
- Reset → all outputs 0; release, no requests → ram_en stays 0 for 20 cycles.
- WB write adr 0x3000_0010, dat 0x0000_BEEF, sel 0xF → ram_en=1, ram_we=1, ram_addr=4, ram_din=0xBEEF 1 cycle after the request; wbs_ack_o one cycle later, single pulse. Then a WB read of the same address → wbs_dat_o=0x0000_BEEF with ack.
- CPU read addr 0x0004 with RAM model returning 0xBEEF → cpu_ready pulses 2 cycles after cpu_req is sampled, cpu_rdata=0xBEEF.
- CPU and WB pending on the same cycle after reset → CPU served first, WB next; sustained contention → strictly alternating grants, no requester waits more than one access.
- cpu_hold=1 with cpu_req=1 for 10 cycles → no CPU grant. WB writes proceed with ack every 3 cycles. Drop hold → CPU granted next IDLE.
- WB adr 0x2000_0000 → no ack, ram_en=0. WB stb dropped during ACCESS → write happens, no ack. wb_rst_i pulsed in ACCESS → no strobe issued, FSM in IDLE.
